// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: instruction port, data port and the shared 16-bit RAM.
// The arbiter uses the slave modport; the core/RAM side uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned RAM_AW = 14
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_done;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_done;
    logic [31:0]       d_rdata;

    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_done, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_done, d_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_done, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_done, d_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit synchronous-read RAM between the I-fetch and D-cache ports, two beats per word.
// Define MEM_ARB_RR_EN for round-robin on contention; default is fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int unsigned RAM_AW = 14
) (
    input logic              clk,
    input logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned BaseW = RAM_AW - 1;

    typedef enum logic [2:0] {
        StIdle,
        StBeat0,
        StBeat1,
        StCap,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_d_q;      // 1 = data port owns the current transfer
    logic              last_owner_d_q;
    logic              we_q;
    logic [BaseW-1:0]  base_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic [RAM_AW-1:0] ram_addr_hold_q;

    logic grant_i, grant_d;

    // Address bits below the word and above the RAM are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[31:RAM_AW+1], bus.i_addr[1:0],
                                bus.d_addr[31:RAM_AW+1], bus.d_addr[1:0]};

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (bus.i_req && bus.d_req) begin
            if (last_owner_d_q) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = bus.i_req;
            grant_d = bus.d_req;
        end
`else
        grant_d = bus.d_req;
        grant_i = bus.i_req && !bus.d_req;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_i || grant_d) begin
                    state_d = StBeat0;
                end
            end
            StBeat0: state_d = StBeat1;
            StBeat1: state_d = StCap;
            StCap:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_d_q       <= 1'b0;
            last_owner_d_q  <= 1'b1;
            we_q            <= 1'b0;
            base_q          <= '0;
            wdata_q         <= '0;
            lo_q            <= '0;
            i_rdata_q       <= '0;
            d_rdata_q       <= '0;
            ram_addr_hold_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_i || grant_d) begin
                        owner_d_q <= grant_d;
                        we_q      <= grant_d && bus.d_we;
                        base_q    <= grant_d ? bus.d_addr[RAM_AW:2] : bus.i_addr[RAM_AW:2];
                        wdata_q   <= grant_d ? bus.d_wdata : 32'h0;
                    end
                end
                StBeat1: begin
                    ram_addr_hold_q <= {base_q, 1'b1};
                    if (!we_q) begin
                        lo_q <= bus.ram_rdata;
                    end
                end
                StCap: begin
                    // Commit the whole word at once so the owner never sees a torn value.
                    if (!we_q) begin
                        if (owner_d_q) begin
                            d_rdata_q <= {bus.ram_rdata, lo_q};
                        end else begin
                            i_rdata_q <= {bus.ram_rdata, lo_q};
                        end
                    end
                end
                StResp: begin
                    last_owner_d_q <= owner_d_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ram_addr  = ram_addr_hold_q;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = 16'h0;
        bus.i_done    = 1'b0;
        bus.d_done    = 1'b0;
        unique case (state_q)
            StBeat0: begin
                bus.ram_addr  = {base_q, 1'b0};
                bus.ram_we    = we_q;
                bus.ram_wdata = wdata_q[15:0];
            end
            StBeat1: begin
                bus.ram_addr  = {base_q, 1'b1};
                bus.ram_we    = we_q;
                bus.ram_wdata = wdata_q[31:16];
            end
            StResp: begin
                bus.i_done = !owner_d_q;
                bus.d_done = owner_d_q;
            end
            default: ;
        endcase
    end

    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared unified RAM between the instruction-fetch port and the data-cache refill/write-back port of the core.
- The RAM is 16 bits wide and has a synchronous read, so every 32-bit transfer runs as two halfword beats under a small FSM.
- The block sits between riscv_core and ram inside riscv_top.
- It replaces direct RAM hookup, so the data cache can write back dirty lines through hardware instead of bench back-door writes.

Parameters:
- RAM_AW, 14, halfword address width of the RAM (16384 halfwords).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request; held until i_done
- i_addr  in  32  byte address, word aligned
- i_done  out  1  one-cycle response pulse
- i_rdata  out  32  fetched word; valid while i_done is high, held afterwards
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write word, 0 = read word
- d_addr  in  32  byte address, word aligned
- d_wdata  in  32  write word
- d_done  out  1  one-cycle response pulse
- d_rdata  out  32  read word; valid while d_done is high, held afterwards
- ram_addr  out  RAM_AW  halfword address
- ram_we  out  1  halfword write enable
- ram_wdata  out  16  halfword write data
- ram_rdata  in  16  read data, valid the cycle after the address is presented

Behaviour:
- Reset values: state IDLE; ram_addr 0, ram_we 0, ram_wdata 0; i_done 0, d_done 0; i_rdata 0, d_rdata 0; last_owner = D.
- No combinational path from any req/addr/wdata input to any RAM output or done output. RAM outputs are decoded from state and latched registers only.
- States: IDLE -> BEAT0 -> BEAT1 -> CAP -> RESP -> IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - On grant at edge N, latch owner, addr, we and wdata. An I grant always latches we = 0.
  - Advance to BEAT0.
- Address mapping: base = latched_addr[RAM_AW:2]. Bits [1:0] and bits above RAM_AW are ignored, so addresses wrap.
- BEAT0: ram_addr = {base,0}; ram_we = we; ram_wdata = wdata[15:0].
- BEAT1:
  - ram_addr = {base,1}; ram_we = we; ram_wdata = wdata[31:16].
  - On a read, capture ram_rdata into rdata[15:0].
- CAP:
  - ram_we = 0.
  - On a read, capture ram_rdata into rdata[31:16].
  - On a write, the state is still traversed so both operation types have equal latency.
- RESP:
  - The owner's done = 1 for exactly this cycle.
  - The owner's rdata register is updated at the end of CAP. The other port's rdata is untouched.
  - Update last_owner, then return to IDLE.
- Latency: grant at edge N, done high in the cycle after edge N+3.
  - A request still held through RESP is regranted at edge N+5, giving a minimum spacing of 5 cycles between done pulses.
- Requester rule: the requester must drop req in its done cycle unless it wants another transaction.
  - Input changes during BEAT0–RESP are ignored.
- Arbitration, default: d_req has fixed priority over i_req.
- Reset mid-operation:
  - Asynchronously forces ram_we = 0, both dones 0 and state IDLE.
  - No response is issued, and a write may be left half done.
  - The requester must reissue after reset.
- Idle RAM outputs: ram_we = 0, ram_addr holds its last value, ram_wdata = 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when i_req and d_req are both pending in IDLE, grant the port that is not last_owner.
  - Since last_owner resets to D, the first contention grants I.
  - A lone requester is always granted.
- Undefined: fixed priority with D over I. The I port may starve under continuous D traffic; this is acceptable because the pipeline stalls on a D miss.

Test Plan:
- I read at i_addr 0x10, RAM hw[8] = 0x1234, hw[9] = 0xABCD -> i_done one cycle after edge N+3; i_rdata = 0xABCD1234; ram_we never high; d_done stays 0.
- D write at d_addr 0x12C, data 0xDEADBEEF -> ram_we high two consecutive cycles: hw[150] = 0xBEEF, then hw[151] = 0xDEAD; d_done one cycle; read-back of 0x12C returns 0xDEADBEEF.
- i_req and d_req asserted at the same edge N, both held until their done:
  - Macro undefined: d_done after edge N+3, i_done after edge N+8.
  - Macro defined: order swapped (I first).
- d_req held through three reads of 0x100/0x104/0x108 -> d_done pulses 5 cycles apart with correct data each time.
- reset_n pulsed low during BEAT1 of a write to 0x200 -> ram_we drops immediately; no d_done; state IDLE; after release, a read of 0x40 completes normally in 4 cycles.
- d_addr 0x8000_0010 -> maps to hw[8]/hw[9], identical to address 0x10.
